mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single unified instruction/data memory port between the pipeline's fetch stage (I-side) and memory stage (D-side). Each requester holds a request until it gets a one-cycle valid pulse. Per-side stall outputs feed the hazard logic's StallF/StallD/StallE equivalents. The block sits between the five-stage datapath and a variable-latency memory, and includes a timeout watchdog for unresponsive memory.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, cycles in a busy state without mem_ready before abort (1..255)
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, held until i_valid
- i_addr  in  AW  fetch byte address
- i_rdata  out  DW  registered fetch data
- i_valid  out  1  one-cycle completion pulse for I-side
- i_err  out  1  qualifies i_valid; 1 = timed out
- d_req  in  1  load/store request, held until d_valid
- d_we  in  1  1 = store
- d_addr  in  AW  data byte address
- d_wdata  in  DW  store data
- d_rdata  out  DW  registered load data
- d_valid  out  1  one-cycle completion pulse for D-side
- d_err  out  1  qualifies d_valid; 1 = timed out
- stall_i  out  1  i_req & ~i_valid (combinational)
- stall_d  out  1  d_req & ~d_valid (combinational)
- mem_req  out  1  registered; high for the whole busy state
- mem_we  out  1  registered write enable (0 for I-side)
- mem_addr  out  AW  registered; {addr[AW-1:2], 2'b00}
- mem_wdata  out  DW  registered store data
- mem_rdata  in  DW  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle completion from memory

## Operation
- States: IDLE, BUSY_I, BUSY_D. Encoding is free. mem_req = (state != IDLE).
- IDLE transitions:
  - d_req=1 → BUSY_D. D-side wins ties because it holds the older instruction.
  - else i_req=1 → BUSY_I.
  - else stay in IDLE.
- Grant: the granted side's addr, we and wdata are latched into the mem_* registers on the transition edge. Requester inputs are ignored after that.
- Completion, BUSY_x with mem_ready=1 at the edge:
  - x_rdata ← mem_rdata on reads. On D-side stores, d_rdata holds its previous value.
  - x_valid=1 and x_err=0 in the next cycle only.
  - Next state is BUSY of the *other* side if that side's req=1 (its operands latched on this edge). Otherwise IDLE.
  - This gives strict alternation when both sides are pending.
- Timeout:
  - A counter clears on every grant and increments each cycle in a busy state.
  - When the counter reaches TIMEOUT with mem_ready still 0, the transaction is aborted: x_valid=1, x_err=1, x_rdata ← 0.
  - The next-state rule is the same as for completion.
  - mem_ready in the same cycle as the timeout wins: normal completion, err=0.
- A req still high in the cycle its valid is high is a new request. It is eligible at the next edge.
- mem_ready while IDLE is ignored.
- Reset (any state, mid-transaction included):
  - State → IDLE; in-flight transaction is dropped.
  - mem_req, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, i_valid, d_valid, i_err, d_err, counter → 0.

## Timing
- Edge 0 samples req. Busy state and mem_* are visible in cycle 1.
- Fastest memory: mem_ready in cycle 1 → valid in cycle 2. Minimum latency is 2 cycles, req-high cycle to valid cycle.
- General latency: 2 + (cycles from mem_req rising to mem_ready).
- Back-to-back alternation: a new grant is visible in the same cycle as the previous side's valid. No idle bubble.
- Same-side repeat: at least one IDLE cycle between consecutive grants to that side.
- mem_req stays high across an alternation handoff. mem_addr/mem_we change on that edge.
- Timeout: with no mem_ready, x_valid asserts TIMEOUT+1 cycles after the busy state is entered.

## Test plan
- **Single fetch:** i_req=1, i_addr=0x0000_0013. Memory returns 0x00A00093 on the first busy cycle → mem_addr=0x10, mem_we=0, i_valid in cycle 2 with i_rdata=0x00A00093, stall_i=1 in cycles 0–1 only.
- **Simultaneous requests:** i_req=d_req=1 in the same cycle, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, memory latency 3 →
  - BUSY_D first with mem_we=1, mem_wdata=0xDEADBEEF.
  - d_valid, then BUSY_I granted on the same edge.
  - i_valid follows 3 memory cycles later.
- **Continuous requests from both sides:** both held high for 6 transactions → grants strictly alternate D, I, D, I, D, I; mem_req never drops.
- **Timeout:** TIMEOUT=5, mem_ready tied 0, single d_req load → d_valid=1 and d_err=1 in cycle 7, d_rdata=0, state IDLE. Same scenario with mem_ready arriving at the counter=5 edge → d_err=0.
- **Reset mid-operation:** rst asserted for 1 cycle during BUSY_I before mem_ready → next cycle all outputs 0, no i_valid. A late mem_ready is ignored.
- **Store then load, same address:** store 0x1234_5678 to 0x40, then load from 0x40 → d_rdata unchanged after the store, d_rdata=0x12345678 after the load.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one memory port shared by the fetch and memory stages.
// D-side wins ties, pending sides alternate, a watchdog aborts stuck accesses.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_valid,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          d_err,
  output logic          stall_i,
  output logic          stall_d,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t        state;
  logic [7:0]    cnt;
  logic          busy;
  logic          hit;
  logic          done;
  logic          err;
  logic          go_d;
  logic          go_i;
  logic          go_idle;
  logic [DW-1:0] rd;
  logic          unused_lsbs;

  assign busy = (state != IDLE);
  assign hit  = (cnt == TO_CNT);
  assign done = busy & (mem_ready | hit);
  assign err  = ~mem_ready;
  assign rd   = mem_ready ? mem_rdata : '0;

  // Who gets the port at this edge; completions hand off to the other side.
  assign go_d = d_req
              & ((state == IDLE)
              | ((state == BUSY_I) & done));
  assign go_i = i_req
              & (((state == IDLE) & ~d_req)
              | ((state == BUSY_D) & done));
  assign go_idle = done & ~go_d & ~go_i;

  assign stall_i = i_req & ~i_valid;
  assign stall_d = d_req & ~d_valid;

  // Word-aligned port: the byte-lane bits of the requests are dropped.
  assign unused_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  // Arbiter FSM: grants, completion/abort pulses, watchdog, port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_err     <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      i_err   <= 1'b0;
      d_err   <= 1'b0;
      if (busy && !done) begin
        cnt <= cnt + 8'd1;
      end
      if ((state == BUSY_I) && done) begin
        i_valid <= 1'b1;
        i_err   <= err;
        i_rdata <= rd;
      end
      if ((state == BUSY_D) && done) begin
        d_valid <= 1'b1;
        d_err   <= err;
        if (err || !mem_we) begin
          d_rdata <= rd;
        end
      end
      unique case (1'b1)
        go_d: begin
          state     <= BUSY_D;
          cnt       <= '0;
          mem_req   <= 1'b1;
          mem_we    <= d_we;
          mem_addr  <= {d_addr[AW-1:2], 2'b00};
          mem_wdata <= d_wdata;
        end
        go_i: begin
          state    <= BUSY_I;
          cnt      <= '0;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= {i_addr[AW-1:2], 2'b00};
        end
        go_idle: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios then random traffic,
// checked every cycle against a transaction-level model of the port.
module tb_mem_port_arbiter;

  localparam int TO = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_err;
  logic        stall_i;
  logic        stall_d;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  mem_port_arbiter #(
    .AW(32),
    .DW(32),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_rdata(i_rdata),
    .i_valid(i_valid),
    .i_err(i_err),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_valid(d_valid),
    .d_err(d_err),
    .stall_i(stall_i),
    .stall_d(stall_d),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: owner 0 = nobody, 1 = fetch, 2 = data; el = busy cycles elapsed.
  logic [31:0] mem_arr [64];
  int          m_own;
  int          m_el;
  int          m_lat;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [31:0] m_irdata;
  logic [31:0] m_drdata;
  logic        m_iv;
  logic        m_ie;
  logic        m_dv;
  logic        m_de;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0;
    m_el = 0;
    m_lat = 0;
    m_addr = '0;
    m_wdata = '0;
    m_we = 1'b0;
    m_irdata = '0;
    m_drdata = '0;
    m_iv = 1'b0;
    m_ie = 1'b0;
    m_dv = 1'b0;
    m_de = 1'b0;
  endtask

  task automatic grant(input int side);
    m_own = side;
    m_el = 0;
    m_lat = $urandom_range(0, TO + 1);
    if (side == 2) begin
      m_addr = {d_addr[31:2], 2'b00};
      m_we = d_we;
      m_wdata = d_wdata;
    end else begin
      m_addr = {i_addr[31:2], 2'b00};
      m_we = 1'b0;
    end
  endtask

  task automatic model_step();
    logic e;
    logic other_req;
    if (rst) begin
      model_reset();
      return;
    end
    m_iv = 1'b0;
    m_ie = 1'b0;
    m_dv = 1'b0;
    m_de = 1'b0;
    if (m_own == 0) begin
      if (d_req) grant(2);
      else if (i_req) grant(1);
    end else if (mem_ready || m_el == TO) begin
      e = !mem_ready;
      if (m_own == 1) begin
        m_iv = 1'b1;
        m_ie = e;
        m_irdata = e ? 32'h0 : mem_rdata;
        other_req = d_req;
      end else begin
        m_dv = 1'b1;
        m_de = e;
        if (e) m_drdata = 32'h0;
        else if (!m_we) m_drdata = mem_rdata;
        else mem_arr[m_addr[7:2]] = m_wdata;
        other_req = i_req;
      end
      if (other_req) grant(3 - m_own);
      else begin
        m_own = 0;
        m_we = 1'b0;
      end
    end else begin
      m_el++;
    end
  endtask

  task automatic check_regs();
    chk("i_valid", i_valid, m_iv);
    chk("i_err", i_err, m_ie);
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_valid", d_valid, m_dv);
    chk("d_err", d_err, m_de);
    chk("d_rdata", d_rdata, m_drdata);
    chk("mem_req", mem_req, m_own != 0);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
  endtask

  // Called at a falling edge with this cycle's inputs already driven.
  task automatic tick();
    #1;
    chk("stall_i", stall_i, i_req & ~m_iv);
    chk("stall_d", stall_d, d_req & ~m_dv);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0;
    i_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    model_reset();
    for (int k = 0; k < 64; k++) mem_arr[k] = $urandom;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_d_rdata", d_rdata, 32'h0);

    // single fetch, memory answers on the first busy cycle
    i_req = 1'b1;
    i_addr = 32'h13;
    tick();
    chk("f_addr", mem_addr, 32'h10);
    chk("f_we", mem_we, 1'b0);
    mem_ready = 1'b1;
    mem_rdata = 32'h00A00093;
    tick();
    chk("f_valid", i_valid, 1'b1);
    chk("f_rdata", i_rdata, 32'h00A00093);
    i_req = 1'b0;
    mem_ready = 1'b0;
    tick();

    // simultaneous requests, store wins, latency 3 each
    i_req = 1'b1;
    i_addr = 32'h44;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h20;
    d_wdata = 32'hDEADBEEF;
    tick();
    chk("s_we", mem_we, 1'b1);
    chk("s_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    tick();
    mem_ready = 1'b1;
    tick();
    chk("s_dvalid", d_valid, 1'b1);
    chk("s_hand_addr", mem_addr, 32'h44);
    chk("s_hand_req", mem_req, 1'b1);
    d_req = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h00510113;
    tick();
    chk("s_ivalid", i_valid, 1'b1);
    chk("s_irdata", i_rdata, 32'h00510113);
    i_req = 1'b0;
    mem_ready = 1'b0;
    tick();

    // both sides held: strict D/I alternation, port never drops
    i_req = 1'b1;
    i_addr = 32'h80;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h90;
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("alt_addr", mem_addr, (k % 2 == 0) ? 32'h90 : 32'h80);
      chk("alt_req", mem_req, 1'b1);
      mem_ready = 1'b1;
      mem_rdata = 32'(k + 1);
      if (k == 5) d_req = 1'b0;
      tick();
    end
    chk("alt_last_i", i_valid, 1'b1);
    chk("alt_idle", mem_req, 1'b0);
    chk("alt_drdata", d_rdata, 32'h5);
    i_req = 1'b0;
    mem_ready = 1'b0;
    tick();

    // ready arrives on the same edge the watchdog expires
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h24;
    tick();
    repeat (5) tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE0001;
    tick();
    chk("to_edge_valid", d_valid, 1'b1);
    chk("to_edge_err", d_err, 1'b0);
    chk("to_edge_rdata", d_rdata, 32'hCAFE0001);
    d_req = 1'b0;
    mem_ready = 1'b0;
    tick();

    // no ready at all: abort in cycle 7
    d_req = 1'b1;
    d_addr = 32'h28;
    tick();
    repeat (6) tick();
    chk("to_valid", d_valid, 1'b1);
    chk("to_err", d_err, 1'b1);
    chk("to_rdata", d_rdata, 32'h0);
    chk("to_idle", mem_req, 1'b0);
    d_req = 1'b0;
    tick();

    // reset in the middle of a fetch, then a late ready
    i_req = 1'b1;
    i_addr = 32'h48;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rm_req", mem_req, 1'b0);
    chk("rm_valid", i_valid, 1'b0);
    chk("rm_rdata", i_rdata, 32'h0);
    chk("rm_addr", mem_addr, 32'h0);
    rst = 1'b0;
    i_req = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    tick();
    chk("rm_late_valid", i_valid, 1'b0);
    chk("rm_late_rdata", i_rdata, 32'h0);
    mem_ready = 1'b0;
    tick();

    // store then load of the same word
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h40;
    d_wdata = 32'h12345678;
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    tick();
    chk("sl_st_valid", d_valid, 1'b1);
    chk("sl_st_rdata", d_rdata, 32'h0);
    mem_ready = 1'b0;
    d_we = 1'b0;
    tick();
    mem_ready = 1'b1;
    mem_rdata = mem_arr[16];
    tick();
    chk("sl_ld_valid", d_valid, 1'b1);
    chk("sl_ld_rdata", d_rdata, 32'h12345678);
    d_req = 1'b0;
    mem_ready = 1'b0;
    tick();

    // random traffic against the model and a word memory
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (i_req && m_iv) begin
        if ($urandom_range(0, 1) == 1) i_addr = $urandom_range(0, 255);
        else i_req = 1'b0;
      end else if (!i_req) begin
        if ($urandom_range(0, 2) == 0) begin
          i_req = 1'b1;
          i_addr = $urandom_range(0, 255);
        end
      end else if (m_own == 1) begin
        i_addr = $urandom;
      end
      if (d_req && m_dv) begin
        if ($urandom_range(0, 1) == 1) begin
          d_we = $urandom_range(0, 1);
          d_addr = $urandom_range(0, 255);
          d_wdata = $urandom;
        end else begin
          d_req = 1'b0;
        end
      end else if (!d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req = 1'b1;
          d_we = $urandom_range(0, 1);
          d_addr = $urandom_range(0, 255);
          d_wdata = $urandom;
        end
      end else if (m_own == 2) begin
        d_addr = $urandom;
        d_wdata = $urandom;
        d_we = $urandom_range(0, 1);
      end
      if (m_own != 0 && m_el == m_lat) begin
        mem_ready = 1'b1;
        mem_rdata = m_we ? $urandom : mem_arr[m_addr[7:2]];
      end else begin
        mem_ready = (m_own == 0) && ($urandom_range(0, 9) == 0);
        mem_rdata = $urandom;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
